mpu_mult_scheduler: RTL and testbench
=====================================

# mpu_mult_scheduler

Sequencing controller for one matrix-multiply operation on the MPU. Accepts a command (two source register addresses and one destination register address) over a valid/ready handshake. Holds the matrix register file load/store requests until both the dispatcher and collector ports are granted, then pulses the dispatcher start. Waits for the collector to report the result written and signals completion. Sits between the instruction decode front end and the matrix register file, dispatcher and collector, and replaces free-running combinational request gating with an explicit per-operation FSM.

## Interface
- `MATRIX_REG_BITS`, 2: address MSB index; all register addresses are `MATRIX_REG_BITS+1` bits wide.
- `TIMEOUT_CYCLES`, 255: watchdog limit on grant wait (used only with `MPU_SCHED_TIMEOUT_EN`).

- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid_in` in 1: command present.
- `cmd_ready_out` out 1: scheduler can accept a command.
- `cmd_src_addr0_in` in MATRIX_REG_BITS+1: multiplicand register.
- `cmd_src_addr1_in` in MATRIX_REG_BITS+1: multiplier register.
- `cmd_dest_addr_in` in MATRIX_REG_BITS+1: destination register.
- `reg_disp_req_out` out 1: dispatcher load request to the register file.
- `reg_collector_req_out` out 1: collector store request to the register file.
- `reg_disp_ready_in` in 1: load grant, level.
- `reg_collector_ready_in` in 1: store grant, level.
- `reg_src_addr_0_out` / `reg_src_addr_1_out` / `reg_dest_addr_out` out MATRIX_REG_BITS+1 each: latched command addresses.
- `disp_start_out` out 1: one-cycle dispatch start pulse.
- `collector_done_in` in 1: one-cycle pulse, result fully stored.
- `done_out` out 1: one-cycle completion pulse.
- `done_dest_addr_out` out MATRIX_REG_BITS+1: destination of the completed operation, valid with `done_out`.
- `busy_out` out 1: high in any state other than IDLE.
- `error_out` out 1: sticky watchdog error; tied 0 without the macro.

## Operation
- States: IDLE, REQ, START, RUN, DONE (ERR with macro).
- IDLE: `cmd_ready_out`=1. When `cmd_valid_in`&`cmd_ready_out`, latch the three addresses and go to REQ.
- REQ: `reg_disp_req_out`=`reg_collector_req_out`=1. Advance to START only in a cycle where both readies sample high. A single ready is not a partial grant; keep waiting.
- START: `disp_start_out`=1 for exactly this cycle; requests stay asserted. Go to RUN.
- RUN: requests stay asserted and hold the register locks. On `collector_done_in` go to DONE.
- DONE: `done_out`=1 and `done_dest_addr_out`=latched dest. Requests deassert. Go to IDLE.
- `collector_done_in` outside RUN is ignored.
- Address outputs hold their latched values from accept until the next accept, including in IDLE.
- Identical src/dest addresses are legal and passed through unchanged; the register file resolves any hazard.

## Timing
- Reset values: state IDLE, all outputs 0 except `cmd_ready_out`=1. Latched addresses and the watchdog counter are 0.
- Accept edge to first request: 1 cycle (REQ is entered on the edge following accept).
- Minimum command-to-`disp_start_out` latency: 2 cycles, when grants are already high on REQ entry.
- `collector_done_in` to `done_out`: 1 cycle. A new command is accepted the cycle after DONE (back-to-back throughput = latency + 1 IDLE cycle).
- `cmd_ready_out` is 0 in every non-IDLE state, so there is no command buffering.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). Requests and `disp_start_out` drop with no completion pulse, and the in-flight command is lost.

## Configuration
- `MPU_SCHED_TIMEOUT_EN` defined:
  - An 8+ bit counter, sized by `$clog2(TIMEOUT_CYCLES+1)`, counts cycles spent in REQ and clears on REQ exit.
  - If the counter reaches `TIMEOUT_CYCLES` while still in REQ, the FSM enters ERR: requests drop, `error_out`=1, `busy_out`=1, `cmd_ready_out`=0.
  - ERR is exited only by `rst`.
- Not defined: no counter and no ERR state; REQ waits forever and `error_out` is constant 0.

## Test plan
- Reset then idle: with `rst` high, `cmd_ready_out`=1 and all other outputs 0. Release reset with no command -> outputs unchanged for 10 cycles.
- Nominal op: accept {src0=1, src1=2, dest=3} with both readies already high -> REQ next cycle, `disp_start_out` 2 cycles after accept. Pulse `collector_done_in` 5 cycles later -> `done_out`=1, `done_dest_addr_out`=3 for one cycle, then `cmd_ready_out`=1.
- Staggered grants: disp ready at cycle +3, collector ready at +6 -> `disp_start_out` only after both are high, i.e. the START cycle follows the +6 sample. No pulse earlier.
- Spurious done: `collector_done_in` pulsed in IDLE and in REQ -> no state change and no `done_out`.
- Reset mid-run: assert `rst` in RUN -> requests, `busy_out` and `done_out` go 0 without waiting for a clock edge. After release, a new command is accepted.
- Watchdog (macro on, `TIMEOUT_CYCLES`=16): readies held low after accept -> `error_out` rises after 16 REQ cycles, requests drop, and `cmd_valid_in` is ignored until reset. With the macro off, the same stimulus gives REQ held indefinitely and `error_out`=0.

Source files
------------

// File: rtl/mpu_mult_scheduler.sv
// Per-operation FSM for one MPU matrix multiply: accept a command, wait for both
// register-file grants, pulse dispatch start, wait for the collector, then report done.
// Optional grant-wait watchdog: define MPU_SCHED_TIMEOUT_EN.
module mpu_mult_scheduler #(
   parameter int MATRIX_REG_BITS = 2,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid_in,
   output logic                     cmd_ready_out,
   input  logic [MATRIX_REG_BITS:0] cmd_src_addr0_in,
   input  logic [MATRIX_REG_BITS:0] cmd_src_addr1_in,
   input  logic [MATRIX_REG_BITS:0] cmd_dest_addr_in,
   output logic                     reg_disp_req_out,
   output logic                     reg_collector_req_out,
   input  logic                     reg_disp_ready_in,
   input  logic                     reg_collector_ready_in,
   output logic [MATRIX_REG_BITS:0] reg_src_addr_0_out,
   output logic [MATRIX_REG_BITS:0] reg_src_addr_1_out,
   output logic [MATRIX_REG_BITS:0] reg_dest_addr_out,
   output logic                     disp_start_out,
   input  logic                     collector_done_in,
   output logic                     done_out,
   output logic [MATRIX_REG_BITS:0] done_dest_addr_out,
   output logic                     busy_out,
   output logic                     error_out
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef MPU_SCHED_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_START, S_RUN, S_DONE, S_ERR} state_e;
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt_q, cnt_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_START, S_RUN, S_DONE} state_e;
`endif

   state_e                   state_q, state_d;
   logic [MATRIX_REG_BITS:0] src0_q, src0_d, src1_q, src1_d, dest_q, dest_d;
   logic                     grant;

   assign grant = reg_disp_ready_in & reg_collector_ready_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src0_q  <= '0;
         src1_q  <= '0;
         dest_q  <= '0;
`ifdef MPU_SCHED_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         src0_q  <= src0_d;
         src1_q  <= src1_d;
         dest_q  <= dest_d;
`ifdef MPU_SCHED_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      src0_d  = src0_q;
      src1_d  = src1_q;
      dest_d  = dest_q;
`ifdef MPU_SCHED_TIMEOUT_EN
      cnt_d   = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_in) begin
               src0_d  = cmd_src_addr0_in;
               src1_d  = cmd_src_addr1_in;
               dest_d  = cmd_dest_addr_in;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Both grants must be high in the same cycle; one alone is not progress.
            if (grant) begin
               state_d = S_START;
            end
`ifdef MPU_SCHED_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d >= TO_LIM) state_d = S_ERR;
            end
`endif
         end
         S_START: state_d = S_RUN;
         S_RUN:   if (collector_done_in) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      cmd_ready_out         = (state_q == S_IDLE);
      busy_out              = (state_q != S_IDLE);
      reg_disp_req_out      = (state_q == S_REQ) || (state_q == S_START) || (state_q == S_RUN);
      reg_collector_req_out = reg_disp_req_out;
      disp_start_out        = (state_q == S_START);
      done_out              = (state_q == S_DONE);
      done_dest_addr_out    = (state_q == S_DONE) ? dest_q : '0;
`ifdef MPU_SCHED_TIMEOUT_EN
      error_out             = (state_q == S_ERR);
`else
      error_out             = 1'b0;
`endif
   end

   assign reg_src_addr_0_out = src0_q;
   assign reg_src_addr_1_out = src1_q;
   assign reg_dest_addr_out  = dest_q;

endmodule

// File: tb/tb_mpu_mult_scheduler.sv
// Bench for mpu_mult_scheduler: event-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mpu_mult_scheduler;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid_in = 1'b0;
   logic       cmd_ready_out;
   logic [2:0] cmd_src_addr0_in = '0, cmd_src_addr1_in = '0, cmd_dest_addr_in = '0;
   logic       reg_disp_req_out, reg_collector_req_out;
   logic       reg_disp_ready_in = 1'b0, reg_collector_ready_in = 1'b0;
   logic [2:0] reg_src_addr_0_out, reg_src_addr_1_out, reg_dest_addr_out;
   logic       disp_start_out;
   logic       collector_done_in = 1'b0;
   logic       done_out;
   logic [2:0] done_dest_addr_out;
   logic       busy_out, error_out;

   int n_chk = 0;
   int n_fail = 0;

   mpu_mult_scheduler #(.MATRIX_REG_BITS(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
      .cmd_src_addr0_in(cmd_src_addr0_in), .cmd_src_addr1_in(cmd_src_addr1_in),
      .cmd_dest_addr_in(cmd_dest_addr_in),
      .reg_disp_req_out(reg_disp_req_out), .reg_collector_req_out(reg_collector_req_out),
      .reg_disp_ready_in(reg_disp_ready_in), .reg_collector_ready_in(reg_collector_ready_in),
      .reg_src_addr_0_out(reg_src_addr_0_out), .reg_src_addr_1_out(reg_src_addr_1_out),
      .reg_dest_addr_out(reg_dest_addr_out),
      .disp_start_out(disp_start_out), .collector_done_in(collector_done_in),
      .done_out(done_out), .done_dest_addr_out(done_dest_addr_out),
      .busy_out(busy_out), .error_out(error_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Timeline model: an operation is described by the cycle numbers of its accept,
   // grant, collector-done and watchdog events; outputs follow from those times.
   int t = 0;
   int a = -1, g = -1, cd = -1, e = -1;
   logic [2:0] ms0 = '0, ms1 = '0, md = '0;

   always @(negedge clk) begin
      bit inf, er;
      if (rst) begin
         chk("rst_ready", cmd_ready_out, 1);
         chk("rst_busy", busy_out, 0);
         chk("rst_req", {reg_disp_req_out, reg_collector_req_out}, 0);
         chk("rst_start_done", {disp_start_out, done_out}, 0);
         chk("rst_err", error_out, 0);
         chk("rst_addrs", {reg_src_addr_0_out, reg_src_addr_1_out, reg_dest_addr_out, done_dest_addr_out}, 0);
         a = -1; g = -1; cd = -1; e = -1;
         ms0 = '0; ms1 = '0; md = '0;
      end else begin
         inf = (a >= 0) && (t > a);
         er  = (e >= 0) && (t > e);
         chk("m_ready", cmd_ready_out, !inf);
         chk("m_busy", busy_out, inf);
         chk("m_dreq", reg_disp_req_out, inf && !er && (cd < 0 || t <= cd));
         chk("m_creq", reg_collector_req_out, inf && !er && (cd < 0 || t <= cd));
         chk("m_start", disp_start_out, (g >= 0) && (t == g + 1));
         chk("m_done", done_out, (cd >= 0) && (t == cd + 1));
         chk("m_done_dest", done_dest_addr_out, ((cd >= 0) && (t == cd + 1)) ? md : 3'd0);
         chk("m_err", error_out, er);
         chk("m_addrs", {reg_src_addr_0_out, reg_src_addr_1_out, reg_dest_addr_out}, {ms0, ms1, md});
         if (!inf && cmd_valid_in) begin
            a = t; g = -1; cd = -1; e = -1;
            ms0 = cmd_src_addr0_in; ms1 = cmd_src_addr1_in; md = cmd_dest_addr_in;
         end else if (inf && !er) begin
            if (g < 0) begin
               if (reg_disp_ready_in && reg_collector_ready_in) g = t;
`ifdef MPU_SCHED_TIMEOUT_EN
               else if (t == a + TO) e = t;
`endif
            end else if (cd < 0) begin
               if (t >= g + 2 && collector_done_in) cd = t;
            end else if (t == cd + 1) begin
               a = -1;
            end
         end
      end
      t++;
   end

   initial begin
      // Reset then idle
      #2;
      chk("reset_ready", cmd_ready_out, 1);
      chk("reset_busy", busy_out, 0);
      cyc(); cyc();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_ready", cmd_ready_out, 1);
         chk("idle_outs", {busy_out, reg_disp_req_out, disp_start_out, done_out, error_out}, 0);
      end

      // Nominal op with grants already high
      reg_disp_ready_in = 1; reg_collector_ready_in = 1;
      cmd_valid_in = 1; cmd_src_addr0_in = 3'd1; cmd_src_addr1_in = 3'd2; cmd_dest_addr_in = 3'd3;
      cyc(); cmd_valid_in = 0;
      chk("nom_req", {reg_disp_req_out, reg_collector_req_out, disp_start_out, cmd_ready_out}, 4'b1100);
      cyc();
      chk("nom_start", disp_start_out, 1);
      cyc();
      chk("nom_run", {reg_disp_req_out, disp_start_out}, 2'b10);
      cyc(); cyc();
      collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("nom_done", {done_out, done_dest_addr_out, reg_disp_req_out}, {1'b1, 3'd3, 1'b0});
      cyc();
      chk("nom_idle", {cmd_ready_out, done_out}, 2'b10);
      chk("nom_addrs", {reg_src_addr_0_out, reg_src_addr_1_out, reg_dest_addr_out}, {3'd1, 3'd2, 3'd3});

      // Staggered grants: disp from +3, collector from +6, START at +7
      reg_disp_ready_in = 0; reg_collector_ready_in = 0;
      cmd_valid_in = 1; cmd_src_addr0_in = 3'd4; cmd_src_addr1_in = 3'd5; cmd_dest_addr_in = 3'd6;
      cyc(); cmd_valid_in = 0;
      for (int k = 1; k <= 7; k++) begin
         chk("stag_start", disp_start_out, (k == 7));
         reg_disp_ready_in = (k >= 3);
         reg_collector_ready_in = (k >= 6);
         if (k < 7) cyc();
      end
      cyc();
      collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("stag_done", {done_out, done_dest_addr_out}, {1'b1, 3'd6});
      cyc();
      reg_disp_ready_in = 0; reg_collector_ready_in = 0;

      // Spurious collector done in IDLE and REQ
      collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("spur_idle", {busy_out, done_out, cmd_ready_out}, 3'b001);
      cmd_valid_in = 1; cmd_src_addr0_in = 3'd7; cmd_src_addr1_in = 3'd0; cmd_dest_addr_in = 3'd1;
      cyc(); cmd_valid_in = 0; collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("spur_req", {reg_disp_req_out, disp_start_out, done_out}, 3'b100);
      reg_disp_ready_in = 1; reg_collector_ready_in = 1;
      cyc();
      chk("spur_start", disp_start_out, 1);
      cyc();
      collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("spur_done", {done_out, done_dest_addr_out}, {1'b1, 3'd1});
      cyc();

      // Asynchronous reset mid-run
      cmd_valid_in = 1; cmd_src_addr0_in = 3'd5; cmd_src_addr1_in = 3'd6; cmd_dest_addr_in = 3'd7;
      cyc(); cmd_valid_in = 0;
      cyc(); cyc();
      chk("pre_rst_run", {reg_disp_req_out, busy_out}, 2'b11);
      @(posedge clk); #3;
      rst = 1;
      #1;
      chk("arst_outs", {reg_disp_req_out, reg_collector_req_out, busy_out, done_out, disp_start_out}, 0);
      chk("arst_ready", cmd_ready_out, 1);
      chk("arst_addr", reg_dest_addr_out, 0);
      cyc(); rst = 0;
      cmd_valid_in = 1; cmd_src_addr0_in = 3'd2; cmd_src_addr1_in = 3'd2; cmd_dest_addr_in = 3'd2;
      cyc(); cmd_valid_in = 0;
      chk("post_rst_req", {busy_out, reg_disp_req_out}, 2'b11);
      chk("same_addrs", {reg_src_addr_0_out, reg_src_addr_1_out, reg_dest_addr_out}, {3'd2, 3'd2, 3'd2});
      cyc(); cyc();
      collector_done_in = 1;
      cyc(); collector_done_in = 0;
      chk("post_rst_done", {done_out, done_dest_addr_out}, {1'b1, 3'd2});
      cyc();

      // Grants withheld: watchdog (or indefinite wait without it)
      reg_disp_ready_in = 0; reg_collector_ready_in = 0;
      cmd_valid_in = 1; cmd_dest_addr_in = 3'd4;
      for (int k = 1; k <= TO + 4; k++) begin
         cyc();
`ifdef MPU_SCHED_TIMEOUT_EN
         chk("wd_err", error_out, (k > TO));
         chk("wd_req", reg_disp_req_out, (k <= TO));
         chk("wd_busy_rdy", {busy_out, cmd_ready_out}, 2'b10);
`else
         chk("wd_err", error_out, 0);
         chk("wd_req", reg_disp_req_out, 1);
`endif
      end
      cmd_valid_in = 0;
      rst = 1;
      cyc(); rst = 0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (error_out || $urandom_range(0, 299) == 0) begin
            rst = 1;
            cyc();
            rst = 0;
         end
         cmd_valid_in           = $urandom_range(0, 1);
         cmd_src_addr0_in       = 3'($urandom_range(0, 7));
         cmd_src_addr1_in       = 3'($urandom_range(0, 7));
         cmd_dest_addr_in       = 3'($urandom_range(0, 7));
         reg_disp_ready_in      = ($urandom_range(0, 9) < 6);
         reg_collector_ready_in = ($urandom_range(0, 9) < 6);
         collector_done_in      = ($urandom_range(0, 3) == 0);
      end
      cmd_valid_in = 0; collector_done_in = 0;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
